// File: rtl/emtf_ptlut_pkg.sv
// Shared types and constants for the PT LUT read scheduler.
package emtf_ptlut_pkg;

  localparam int NTRK    = 3;
  localparam int PT_BW   = 9;
  localparam int ADDR_BW = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } ptlut_st_t;

  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } ptlut_tag_t;

endpackage

// File: rtl/ptlut_tag_pipe.sv
// Fixed-depth delay line carrying read tags alongside the PT LUT latency.
// An occupancy bit per stage separates "slot present" from the track-valid flag in the tag.
module ptlut_tag_pipe
  import emtf_ptlut_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_en,
  input  ptlut_tag_t in_tag,
  output logic       out_en,
  output ptlut_tag_t out_tag
);

  logic       [DEPTH-1:0] en_q;
  ptlut_tag_t [DEPTH-1:0] tag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q  <= '0;
      tag_q <= '0;
    end else begin
      en_q[0]  <= in_en;
      tag_q[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        en_q[i]  <= en_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign out_en  = en_q[DEPTH-1];
  assign out_tag = tag_q[DEPTH-1];

endmodule

// File: rtl/ptlut_rd_sched.sv
// Shares one PT LUT read port among the 3 best tracks of a BX with constant latency.
// Optional statistics counters are enabled by defining PTLUT_STAT_EN.
module ptlut_rd_sched #(
  parameter int MEM_LAT = 3,
  parameter int ADDR_BW = 30,
  parameter int PT_BW   = 9
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef PTLUT_STAT_EN
  input  logic                   clr_stat,
  output logic [31:0]            rd_cnt,
  output logic [15:0]            ovr_cnt,
`endif
  input  logic                   bx_stb,
  input  logic [2:0][ADDR_BW-1:0] ptlut_addr,
  input  logic [2:0]             trk_vld,
  output logic                   mem_rd,
  output logic [ADDR_BW-1:0]     mem_addr,
  input  logic [PT_BW-1:0]       mem_dout,
  output logic [2:0][PT_BW-1:0]  pt_out,
  output logic                   pt_vld,
  output logic [3:0]             align_sel,
  output logic                   overrun,
  output logic                   busy
);

  import emtf_ptlut_pkg::*;

  ptlut_st_t                      st_q, st_d;
  logic [2:0]                     cnt_q, cnt_d;
  logic [NTRK-1:0][ADDR_BW-1:0]   addr_q, addr_d;
  logic [NTRK-1:0]                vld_q, vld_d;
  logic                           ovr_q, ovr_d;
  logic [ADDR_BW-1:0]             hold_q;
  logic [NTRK-1:0][PT_BW-1:0]     pt_q;
  logic [1:0]                     slot;
  logic                           accept;
  ptlut_tag_t                     in_tag, cap_tag;
  logic                           cap_en;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    addr_d = addr_q;
    vld_d  = vld_q;
    ovr_d  = 1'b0;
    accept = 1'b0;
    case (st_q)
      IDLE:  accept = bx_stb;
      ISSUE: begin
        ovr_d = bx_stb;
        if (cnt_q == 3'd2) begin
          st_d  = WAIT;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WAIT: begin
        ovr_d = bx_stb;
        if (cnt_q == 3'(MEM_LAT - 1)) begin
          st_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        st_d   = IDLE;
        accept = bx_stb;
      end
      default: st_d = IDLE;
    endcase
    // A new BX from IDLE or DONE restarts the slot sequence immediately.
    if (accept) begin
      st_d   = ISSUE;
      cnt_d  = '0;
      addr_d = ptlut_addr;
      vld_d  = trk_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      addr_q <= '0;
      vld_q  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      vld_q  <= vld_d;
      ovr_q  <= ovr_d;
    end
  end

  assign slot     = cnt_q[1:0];
  assign mem_rd   = (st_q == ISSUE) && vld_q[slot];
  assign mem_addr = mem_rd ? addr_q[slot] : hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else if (mem_rd) begin
      hold_q <= addr_q[slot];
    end
  end

  // Every slot sends a tag, even for invalid tracks, so their pt word is cleared on schedule.
  assign in_tag.vld = vld_q[slot];
  assign in_tag.idx = slot;

  ptlut_tag_pipe #(
    .DEPTH (MEM_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_en   (st_q == ISSUE),
    .in_tag  (in_tag),
    .out_en  (cap_en),
    .out_tag (cap_tag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pt_q <= '0;
    end else if (cap_en) begin
      pt_q[cap_tag.idx] <= cap_tag.vld ? mem_dout : '0;
    end
  end

  assign pt_out    = pt_q;
  assign pt_vld    = (st_q == DONE);
  assign overrun   = ovr_q;
  assign busy      = (st_q == ISSUE) || (st_q == WAIT);
  assign align_sel = 4'(MEM_LAT + 4);

`ifdef PTLUT_STAT_EN
  logic [31:0] rd_cnt_q;
  logic [15:0] ovr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_stat) begin
      rd_cnt_q  <= '0;
      ovr_cnt_q <= '0;
    end else begin
      if (mem_rd && (rd_cnt_q != '1)) begin
        rd_cnt_q <= rd_cnt_q + 32'd1;
      end
      if (ovr_d && (ovr_cnt_q != '1)) begin
        ovr_cnt_q <= ovr_cnt_q + 16'd1;
      end
    end
  end

  assign rd_cnt  = rd_cnt_q;
  assign ovr_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_ptlut_rd_sched.sv
// Directed bench for ptlut_rd_sched with a fixed-latency LUT model (pt = addr[8:0] ^ 0x0F0).
module tb_ptlut_rd_sched;

  localparam int MEM_LAT = 3;
  localparam int ADDR_BW = 30;
  localparam int PT_BW   = 9;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      bx_stb;
  logic [2:0][ADDR_BW-1:0]   ptlut_addr;
  logic [2:0]                trk_vld;
  logic                      mem_rd;
  logic [ADDR_BW-1:0]        mem_addr;
  logic [PT_BW-1:0]          mem_dout;
  logic [2:0][PT_BW-1:0]     pt_out;
  logic                      pt_vld;
  logic [3:0]                align_sel;
  logic                      overrun;
  logic                      busy;
`ifdef PTLUT_STAT_EN
  logic                      clr_stat;
  logic [31:0]               rd_cnt;
  logic [15:0]               ovr_cnt;
`endif

  int nChecks = 0;
  int nPass   = 0;

  typedef struct {
    logic [2:0]              vld;
    logic [2:0][ADDR_BW-1:0] addr;
    logic [2:0]              expRd;
    logic [2:0][PT_BW-1:0]   expPt;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  ptlut_rd_sched #(
    .MEM_LAT (MEM_LAT),
    .ADDR_BW (ADDR_BW),
    .PT_BW   (PT_BW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef PTLUT_STAT_EN
    .clr_stat   (clr_stat),
    .rd_cnt     (rd_cnt),
    .ovr_cnt    (ovr_cnt),
`endif
    .bx_stb     (bx_stb),
    .ptlut_addr (ptlut_addr),
    .trk_vld    (trk_vld),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .pt_out     (pt_out),
    .pt_vld     (pt_vld),
    .align_sel  (align_sel),
    .overrun    (overrun),
    .busy       (busy)
  );

  function automatic logic [PT_BW-1:0] lut(input logic [ADDR_BW-1:0] a);
    return a[8:0] ^ 9'h0F0;
  endfunction

  // LUT model: returns garbage when not read, so mistimed captures are visible.
  logic [PT_BW-1:0] dpipe [MEM_LAT];
  always @(posedge clk) begin
    dpipe[0] <= mem_rd ? lut(mem_addr) : 9'h1AA;
    for (int i = 1; i < MEM_LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign mem_dout = dpipe[MEM_LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One complete BX from IDLE: bx_stb in cycle 0, pt_vld expected in cycle 7.
  task automatic applyStimulus(input vec_t v);
    logic [2:0] rdSeen;
    logic [1:0] s;
    int addrErr, strayRd, earlyVld;
    rdSeen = '0; addrErr = 0; strayRd = 0; earlyVld = 0;
    bx_stb = 1'b1; ptlut_addr = v.addr; trk_vld = v.vld;
    tick();
    bx_stb = 1'b0; ptlut_addr = '0; trk_vld = '0;
    for (int c = 1; c <= 7; c++) begin
      if (c <= 3) begin
        s = 2'(c - 1);
        rdSeen = {mem_rd, rdSeen[2:1]};
        if (mem_rd && (mem_addr !== v.addr[s])) addrErr++;
      end else if (mem_rd) begin
        strayRd++;
      end
      if (c < 7 && pt_vld) earlyVld++;
      if (c == 7) begin
        checkOutput("pt_vld at cycle 7", 64'(pt_vld), 64'(1));
        checkOutput("pt_out", 64'(pt_out), 64'(v.expPt));
      end
      tick();
    end
    checkOutput("mem_rd slots", 64'(rdSeen), 64'(v.expRd));
    checkOutput("mem_addr errors", 64'(addrErr), 64'(0));
    checkOutput("stray mem_rd", 64'(strayRd + earlyVld), 64'(0));
    checkOutput("pt_vld one clock", 64'(pt_vld), 64'(0));
  endtask

  initial begin
    logic [2:0][ADDR_BW-1:0] a;
    logic [2:0][PT_BW-1:0]   expQ [100];
    logic [2:0][PT_BW-1:0]   ptAt7;
    logic [15:0] ovrMask, vldMask, busyMask;
    int vldErr, ptErr, vldCnt, ovrSeen, k;

    vecs[0] = '{vld: 3'b111, addr: {30'h3_0123, 30'h0FF, 30'h001}, expRd: 3'b111,
                expPt: {9'h1D3, 9'h00F, 9'h0F1}};
    vecs[1] = '{vld: 3'b010, addr: {30'h077, 30'h1F0, 30'h005}, expRd: 3'b010,
                expPt: {9'h000, 9'h100, 9'h000}};
    vecs[2] = '{vld: 3'b101, addr: {30'h1_0000, 30'h003, 30'h2AA}, expRd: 3'b101,
                expPt: {9'h0F0, 9'h000, 9'h05A}};
    vecs[3] = '{vld: 3'b000, addr: {30'h055, 30'h066, 30'h077}, expRd: 3'b000,
                expPt: {9'h000, 9'h000, 9'h000}};
    vecs[4] = '{vld: 3'b110, addr: {30'h3FFF_FFFF, 30'h1FF, 30'h004}, expRd: 3'b110,
                expPt: {9'h10F, 9'h10F, 9'h000}};

    rst = 1'b1; bx_stb = 1'b0; ptlut_addr = '0; trk_vld = '0;
`ifdef PTLUT_STAT_EN
    clr_stat = 1'b0;
`endif
    tick(); tick(); tick();
    checkOutput("reset mem_rd", 64'(mem_rd), 64'(0));
    checkOutput("reset mem_addr", 64'(mem_addr), 64'(0));
    checkOutput("reset pt_out", 64'(pt_out), 64'(0));
    checkOutput("reset pt_vld", 64'(pt_vld), 64'(0));
    checkOutput("reset overrun", 64'(overrun), 64'(0));
    checkOutput("reset busy", 64'(busy), 64'(0));
    checkOutput("align_sel", 64'(align_sel), 64'(MEM_LAT + 4));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    // Back-to-back BX every 7 clocks: DONE accepts the next bx_stb with no gap.
    vldErr = 0; ptErr = 0; vldCnt = 0; ovrSeen = 0;
    for (int t = 0; t <= 708; t++) begin
      if (pt_vld) begin
        vldCnt++;
        if (t < 7 || (t % 7) != 0 || t > 700) vldErr++;
        else if (pt_out !== expQ[t/7 - 1]) ptErr++;
      end else if (t >= 7 && (t % 7) == 0 && t <= 700) begin
        vldErr++;
      end
      if (overrun) ovrSeen++;
      if ((t % 7) == 0 && t < 700) begin
        k = t / 7;
        a = {30'(k * 7 + 300), 30'(k * 5 + 200), 30'(k * 3 + 1)};
        expQ[k] = {lut(a[2]), lut(a[1]), lut(a[0])};
        bx_stb = 1'b1; trk_vld = 3'b111; ptlut_addr = a;
      end else begin
        bx_stb = 1'b0;
      end
      tick();
    end
    checkOutput("period7 pt_vld timing", 64'(vldErr), 64'(0));
    checkOutput("period7 pt_vld count", 64'(vldCnt), 64'(100));
    checkOutput("period7 pt_out", 64'(ptErr), 64'(0));
    checkOutput("period7 overrun", 64'(ovrSeen), 64'(0));

    // Second bx_stb while waiting is dropped and flagged.
    ovrMask = '0; vldMask = '0; busyMask = '0; ptAt7 = '0;
    for (int t = 0; t <= 10; t++) begin
      ovrMask  = ovrMask  | (16'(overrun) << t);
      vldMask  = vldMask  | (16'(pt_vld)  << t);
      busyMask = busyMask | (16'(busy)    << t);
      if (t == 7) ptAt7 = pt_out;
      bx_stb = (t == 0) || (t == 4);
      trk_vld = (t == 0) ? vecs[0].vld : vecs[4].vld;
      ptlut_addr = (t == 0) ? vecs[0].addr : vecs[4].addr;
      tick();
    end
    checkOutput("dropped overrun cycle", 64'(ovrMask), 64'h0020);
    checkOutput("dropped pt_vld cycle", 64'(vldMask), 64'h0080);
    checkOutput("dropped busy cycles", 64'(busyMask), 64'h007E);
    checkOutput("dropped pt_out", 64'(ptAt7), 64'(vecs[0].expPt));

    // Reset during the wait phase abandons the sequence.
    vldMask = '0;
    for (int t = 0; t <= 12; t++) begin
      vldMask = vldMask | (16'(pt_vld) << t);
      bx_stb = (t == 0);
      trk_vld = vecs[0].vld;
      ptlut_addr = vecs[0].addr;
      rst = (t == 5);
      tick();
    end
    rst = 1'b0;
    checkOutput("midreset pt_vld", 64'(vldMask), 64'(0));
    checkOutput("midreset pt_out", 64'(pt_out), 64'(0));
    checkOutput("midreset mem_addr", 64'(mem_addr), 64'(0));
    checkOutput("midreset busy", 64'(busy), 64'(0));
    applyStimulus(vecs[2]);

`ifdef PTLUT_STAT_EN
    clr_stat = 1'b1; tick(); clr_stat = 1'b0;
    for (int b = 0; b < 10; b++) begin
      for (int t = 0; t < 8; t++) begin
        bx_stb = (t == 0) || (b < 2 && t == 4);
        trk_vld = 3'b111;
        ptlut_addr = vecs[0].addr;
        tick();
      end
    end
    bx_stb = 1'b0;
    checkOutput("rd_cnt", 64'(rd_cnt), 64'(30));
    checkOutput("ovr_cnt", 64'(ovr_cnt), 64'(2));
    clr_stat = 1'b1; tick(); clr_stat = 1'b0;
    checkOutput("rd_cnt cleared", 64'(rd_cnt), 64'(0));
    checkOutput("ovr_cnt cleared", 64'(ovr_cnt), 64'(0));
    bx_stb = 1'b1; tick(); bx_stb = 1'b0;
    clr_stat = 1'b1; tick(); clr_stat = 1'b0;
    checkOutput("clr_stat priority", 64'(rd_cnt), 64'(0));
    for (int t = 0; t < 8; t++) tick();
    checkOutput("rd_cnt after clear", 64'(rd_cnt), 64'(2));
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
